// File: rtl/ttt_game_ctrl.sv
// -----------------------------------------------------------------------------
// ttt_game_ctrl
// Move controller for a tic-tac-toe board. It owns the 18-bit grid consumed
// by the pixel-sweep drawer, accepts one move request at a time, rejects
// illegal moves, places the current player's mark and then scans the eight
// win lines one per cycle to decide between win, draw and next turn.
//
// Parameters
//   FIRST_PLAYER  mark of the player moving first after reset/new game (01=X, 10=O)
//   NUM_CELLS     number of board cells (fixed at 9)
//
// Ports
//   clk         in   1   system clock
//   resetn      in   1   synchronous active-low reset
//   new_game    in   1   pulse: clear the board and restart (any state)
//   move_valid  in   1   pulse: move request, sampled only while waiting
//   move_cell   in   4   requested cell 0..8, row-major, 0 = top-left
//   grid        out  18  cell k in grid[17-2k:16-2k]; 00 empty, 01 X, 10 O, 11 highlight
//   turn        out  2   mark of the player to move
//   busy        out  1   placement/evaluation in progress, requests ignored
//   move_ack    out  1   pulse: move placed, no win/draw, turn passed on
//   move_err    out  1   pulse: move rejected
//   winner      out  2   00 none, 01 X, 10 O
//   game_over   out  1   game finished (win or draw)
//   draw        out  1   board full with no winner
//
// Build option
//   TTT_WIN_HIGHLIGHT_EN : when defined, a win costs one extra cycle in which
//   the three winning cells are rewritten to 2'b11 before the game is frozen.
// -----------------------------------------------------------------------------
module ttt_game_ctrl #(
    parameter logic [1:0] FIRST_PLAYER = 2'b01,
    parameter int         NUM_CELLS    = 9
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_cell,
    output logic [17:0] grid,
    output logic [1:0]  turn,
    output logic        busy,
    output logic        move_ack,
    output logic        move_err,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic        draw
);

    localparam logic [3:0] LAST_CELL = 4'(NUM_CELLS - 1);
    localparam logic [3:0] MAX_CNT   = 4'(NUM_CELLS);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_PLACE  = 3'd1,
        S_EVAL   = 3'd2,
        S_OVER   = 3'd3,
        S_HILITE = 3'd4
    } state_t;

    // Read the 2-bit mark of one cell; out-of-range cells read as empty.
    function automatic logic [1:0] cell_get(input logic [17:0] g, input logic [3:0] c);
        logic [1:0] v;
        case (c)
            4'd0:    v = g[17:16];
            4'd1:    v = g[15:14];
            4'd2:    v = g[13:12];
            4'd3:    v = g[11:10];
            4'd4:    v = g[9:8];
            4'd5:    v = g[7:6];
            4'd6:    v = g[5:4];
            4'd7:    v = g[3:2];
            4'd8:    v = g[1:0];
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    // Return the grid with one cell overwritten by mark m.
    function automatic logic [17:0] cell_put(input logic [17:0] g, input logic [3:0] c,
                                             input logic [1:0] m);
        logic [17:0] r;
        r = g;
        case (c)
            4'd0:    r[17:16] = m;
            4'd1:    r[15:14] = m;
            4'd2:    r[13:12] = m;
            4'd3:    r[11:10] = m;
            4'd4:    r[9:8]   = m;
            4'd5:    r[7:6]   = m;
            4'd6:    r[5:4]   = m;
            4'd7:    r[3:2]   = m;
            4'd8:    r[1:0]   = m;
            default: r        = g;
        endcase
        return r;
    endfunction

    // Win-line table: three cell indices packed {a, b, c}, rows, columns, diagonals.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        logic [11:0] l;
        case (idx)
            3'd0:    l = {4'd0, 4'd1, 4'd2};
            3'd1:    l = {4'd3, 4'd4, 4'd5};
            3'd2:    l = {4'd6, 4'd7, 4'd8};
            3'd3:    l = {4'd0, 4'd3, 4'd6};
            3'd4:    l = {4'd1, 4'd4, 4'd7};
            3'd5:    l = {4'd2, 4'd5, 4'd8};
            3'd6:    l = {4'd0, 4'd4, 4'd8};
            3'd7:    l = {4'd2, 4'd4, 4'd6};
            default: l = {4'd0, 4'd1, 4'd2};
        endcase
        return l;
    endfunction

    state_t      state_r, state_n;
    logic [17:0] grid_r, grid_n;
    logic [1:0]  turn_r, turn_n;
    logic [1:0]  winner_r, winner_n;
    logic        busy_r, busy_n;
    logic        ack_r, ack_n;
    logic        err_r, err_n;
    logic        game_over_r, game_over_n;
    logic        draw_r, draw_n;
    logic [3:0]  cnt_r, cnt_n;
    logic [2:0]  line_r, line_n;
    logic [3:0]  cell_r, cell_n;

    logic [11:0] line_s;
    logic [3:0]  la_s, lb_s, lc_s;
    logic        win_s;
    logic        legal_s;

    assign line_s  = line_cells(line_r);
    assign la_s    = line_s[11:8];
    assign lb_s    = line_s[7:4];
    assign lc_s    = line_s[3:0];
    // turn is never 00, so empty cells can never complete a line.
    assign win_s   = (cell_get(grid_r, la_s) == turn_r) &&
                     (cell_get(grid_r, lb_s) == turn_r) &&
                     (cell_get(grid_r, lc_s) == turn_r);
    assign legal_s = (move_cell <= LAST_CELL) && (cell_get(grid_r, move_cell) == 2'b00);

    // Next-state and next-output logic; new_game overrides everything else.
    always_comb begin
        state_n     = state_r;
        grid_n      = grid_r;
        turn_n      = turn_r;
        winner_n    = winner_r;
        ack_n       = 1'b0;
        err_n       = 1'b0;
        game_over_n = game_over_r;
        draw_n      = draw_r;
        cnt_n       = cnt_r;
        line_n      = line_r;
        cell_n      = cell_r;
        if (new_game) begin
            state_n     = S_WAIT;
            grid_n      = 18'd0;
            turn_n      = FIRST_PLAYER;
            winner_n    = 2'b00;
            game_over_n = 1'b0;
            draw_n      = 1'b0;
            cnt_n       = 4'd0;
            line_n      = 3'd0;
            cell_n      = 4'd0;
        end else begin
            case (state_r)
                S_WAIT: begin
                    if (move_valid) begin
                        if (legal_s) begin
                            cell_n  = move_cell;
                            state_n = S_PLACE;
                        end else begin
                            err_n = 1'b1;
                        end
                    end else begin
                        state_n = S_WAIT;
                    end
                end
                S_PLACE: begin
                    grid_n  = cell_put(grid_r, cell_r, turn_r);
                    cnt_n   = (cnt_r >= MAX_CNT) ? MAX_CNT : cnt_r + 4'd1;
                    line_n  = 3'd0;
                    state_n = S_EVAL;
                end
                S_EVAL: begin
                    if (win_s) begin
                        // line_r is left pointing at the winning line for the highlight pass.
                        winner_n    = turn_r;
                        game_over_n = 1'b1;
`ifdef TTT_WIN_HIGHLIGHT_EN
                        state_n     = S_HILITE;
`else
                        state_n     = S_OVER;
`endif
                    end else if (line_r == 3'd7) begin
                        if (cnt_r == MAX_CNT) begin
                            draw_n      = 1'b1;
                            game_over_n = 1'b1;
                            state_n     = S_OVER;
                        end else begin
                            turn_n  = (turn_r == 2'b01) ? 2'b10 : 2'b01;
                            ack_n   = 1'b1;
                            state_n = S_WAIT;
                        end
                    end else begin
                        line_n = line_r + 3'd1;
                    end
                end
`ifdef TTT_WIN_HIGHLIGHT_EN
                S_HILITE: begin
                    grid_n  = cell_put(cell_put(cell_put(grid_r, la_s, 2'b11),
                                                lb_s, 2'b11), lc_s, 2'b11);
                    state_n = S_OVER;
                end
`endif
                S_OVER: begin
                    if (move_valid) begin
                        err_n = 1'b1;
                    end else begin
                        err_n = 1'b0;
                    end
                end
                default: begin
                    state_n = S_WAIT;
                end
            endcase
        end
        busy_n = (state_n == S_PLACE) || (state_n == S_EVAL) || (state_n == S_HILITE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= S_WAIT;
            grid_r      <= 18'd0;
            turn_r      <= FIRST_PLAYER;
            winner_r    <= 2'b00;
            busy_r      <= 1'b0;
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            game_over_r <= 1'b0;
            draw_r      <= 1'b0;
            cnt_r       <= 4'd0;
            line_r      <= 3'd0;
            cell_r      <= 4'd0;
        end else begin
            state_r     <= state_n;
            grid_r      <= grid_n;
            turn_r      <= turn_n;
            winner_r    <= winner_n;
            busy_r      <= busy_n;
            ack_r       <= ack_n;
            err_r       <= err_n;
            game_over_r <= game_over_n;
            draw_r      <= draw_n;
            cnt_r       <= cnt_n;
            line_r      <= line_n;
            cell_r      <= cell_n;
        end
    end

    assign grid      = grid_r;
    assign turn      = turn_r;
    assign busy      = busy_r;
    assign move_ack  = ack_r;
    assign move_err  = err_r;
    assign winner    = winner_r;
    assign game_over = game_over_r;
    assign draw      = draw_r;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ttt_game_ctrl
// Directed scoreboard bench for ttt_game_ctrl. Each move pushes its expected
// response (ack, err or game-over) with the expected board state; a monitor
// pops and compares whenever the controller reports a response.
// -----------------------------------------------------------------------------
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        new_game;
    logic        move_valid;
    logic [3:0]  move_cell;
    logic [17:0] grid;
    logic [1:0]  turn;
    logic        busy;
    logic        move_ack;
    logic        move_err;
    logic [1:0]  winner;
    logic        game_over;
    logic        draw;

    localparam logic [1:0] K_ACK  = 2'd1;
    localparam logic [1:0] K_ERR  = 2'd2;
    localparam logic [1:0] K_OVER = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [17:0] grid;
        logic [1:0]  turn;
        logic [1:0]  winner;
        logic        draw;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        go_prev = 1'b0;

    logic [17:0] m_grid;
    logic [1:0]  m_turn;
    logic [1:0]  m_winner;
    logic        m_draw;
    int          lat;
    logic [17:0] win_grid;

    ttt_game_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_cell  (move_cell),
        .grid       (grid),
        .turn       (turn),
        .busy       (busy),
        .move_ack   (move_ack),
        .move_err   (move_err),
        .winner     (winner),
        .game_over  (game_over),
        .draw       (draw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] put(input logic [17:0] g, input int c, input logic [1:0] m);
        g[17-2*c -: 2] = m;
        return g;
    endfunction

    task automatic model_clear();
        m_grid   = 18'd0;
        m_turn   = 2'b01;
        m_winner = 2'b00;
        m_draw   = 1'b0;
    endtask

    // Push the expected response, issue one move, wait (bounded) for a response.
    task automatic play(input logic [3:0] c, input logic [1:0] kind, input logic is_draw,
                        output int lat_o);
        exp_t e;
        logic go0;
        if (kind != K_ERR) m_grid = put(m_grid, int'(c), m_turn);
        if (kind == K_ACK) m_turn = (m_turn == 2'b01) ? 2'b10 : 2'b01;
        if (kind == K_OVER) begin
            if (is_draw) m_draw = 1'b1;
            else m_winner = m_turn;
        end
        e.kind = kind; e.grid = m_grid; e.turn = m_turn; e.winner = m_winner; e.draw = m_draw;
        sb_q.push_back(e);
        @(negedge clk);
        go0 = game_over;
        move_valid = 1'b1;
        move_cell  = c;
        @(negedge clk);
        move_valid = 1'b0;
        move_cell  = 4'd0;
        lat_o = 1;
        while (!(move_ack || move_err || (game_over && !go0)) && lat_o < 20) begin
            @(negedge clk);
            lat_o++;
        end
        if (lat_o >= 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL response_timeout: got none expected kind %0d", kind);
        end
        @(negedge clk);
    endtask

    task automatic pulse_new_game();
        @(negedge clk);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_grid"},      grid,               18'd0);
        chk({tag, "_turn"},      18'(turn),          18'(2'b01));
        chk({tag, "_winner"},    18'(winner),        18'd0);
        chk({tag, "_busy"},      18'(busy),          18'd0);
        chk({tag, "_game_over"}, 18'(game_over),     18'd0);
        chk({tag, "_draw"},      18'(draw),          18'd0);
        chk({tag, "_pulses"},    18'({move_ack, move_err}), 18'd0);
    endtask

    // Monitor: pop and compare one expectation per reported response.
    always @(negedge clk) begin : monitor
        logic [1:0] k;
        exp_t       e;
        k = move_ack ? K_ACK : move_err ? K_ERR : (game_over && !go_prev) ? K_OVER : 2'd0;
        go_prev <= game_over;
        if (resetn && k != 2'd0) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_response: got kind %0d expected none", k);
            end else begin
                e = sb_q.pop_front();
                chk("resp_kind",   18'(k),      18'(e.kind));
                chk("resp_grid",   grid,        e.grid);
                chk("resp_turn",   18'(turn),   18'(e.turn));
                chk("resp_winner", 18'(winner), 18'(e.winner));
                chk("resp_draw",   18'(draw),   18'(e.draw));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b0; new_game = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
        model_clear();
        repeat (3) @(negedge clk);
        chk_cleared("reset");
        resetn = 1'b1;

        // 1: first move X at centre, check grid timing and ack latency.
        fork
            play(4'd4, K_ACK, 1'b0, lat);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("t1_grid_T1", grid, 18'd0);
                @(negedge clk);
                chk("t1_grid_T2", grid, 18'h00100);
                chk("t1_busy_T2", 18'(busy), 18'd1);
            end
        join
        chk("t1_ack_latency", 18'(lat), 18'd10);
        chk("t1_turn", 18'(turn), 18'(2'b10));

        // 2: occupied cell is rejected.
        play(4'd4, K_ERR, 1'b0, lat);
        chk("t2_err_latency", 18'(lat), 18'd1);

        // 3: out-of-range cell rejected; a request while busy is ignored.
        play(4'd9, K_ERR, 1'b0, lat);
        fork
            play(4'd0, K_ACK, 1'b0, lat);
            begin
                @(negedge clk);
                repeat (3) @(negedge clk);
                chk("t3_busy", 18'(busy), 18'd1);
                move_valid = 1'b1;
                move_cell  = 4'd5;
                @(negedge clk);
                move_valid = 1'b0;
                move_cell  = 4'd0;
            end
        join

        // 4: X wins on the top row at line 0.
        pulse_new_game();
        chk_cleared("ng1");
        play(4'd0, K_ACK, 1'b0, lat);
        play(4'd3, K_ACK, 1'b0, lat);
        play(4'd1, K_ACK, 1'b0, lat);
        play(4'd4, K_ACK, 1'b0, lat);
        play(4'd2, K_OVER, 1'b0, lat);
        chk("t4_win_latency", 18'(lat), 18'd3);
        repeat (3) @(negedge clk);
`ifdef TTT_WIN_HIGHLIGHT_EN
        win_grid = 18'h3FA00;
`else
        win_grid = 18'h15A00;
`endif
        chk("t4_final_grid", grid, win_grid);
        chk("t4_winner", 18'(winner), 18'(2'b01));
        chk("t4_game_over", 18'(game_over), 18'd1);
        m_grid = win_grid;
        play(4'd5, K_ERR, 1'b0, lat);

        // 5: full board without a line ends in a draw.
        pulse_new_game();
        chk_cleared("ng2");
        play(4'd0, K_ACK, 1'b0, lat);
        play(4'd1, K_ACK, 1'b0, lat);
        play(4'd2, K_ACK, 1'b0, lat);
        play(4'd4, K_ACK, 1'b0, lat);
        play(4'd3, K_ACK, 1'b0, lat);
        play(4'd5, K_ACK, 1'b0, lat);
        play(4'd7, K_ACK, 1'b0, lat);
        play(4'd6, K_ACK, 1'b0, lat);
        play(4'd8, K_OVER, 1'b1, lat);
        chk("t5_draw_latency", 18'(lat), 18'd10);
        chk("t5_draw_grid", grid, 18'h196A5);
        chk("t5_draw", 18'(draw), 18'd1);
        chk("t5_winner", 18'(winner), 18'd0);
        play(4'd0, K_ERR, 1'b0, lat);

        // new_game in the same cycle as a legal move wins.
        pulse_new_game();
        @(negedge clk);
        new_game = 1'b1; move_valid = 1'b1; move_cell = 4'd4;
        @(negedge clk);
        new_game = 1'b0; move_valid = 1'b0; move_cell = 4'd0;
        repeat (3) @(negedge clk);
        chk_cleared("ng_override");

        // 6: new_game aborts an evaluation in progress.
        play(4'd0, K_ACK, 1'b0, lat);
        @(negedge clk);
        move_valid = 1'b1; move_cell = 4'd8;
        @(negedge clk);
        move_valid = 1'b0; move_cell = 4'd0;
        repeat (3) @(negedge clk);
        chk("t6_busy_eval", 18'(busy), 18'd1);
        new_game = 1'b1;
        @(negedge clk);
        new_game = 1'b0;
        model_clear();
        chk_cleared("t6_abort");
        repeat (12) @(negedge clk);

        // resetn mid-game returns everything to reset values.
        play(4'd0, K_ACK, 1'b0, lat);
        play(4'd1, K_ACK, 1'b0, lat);
        @(negedge clk);
        move_valid = 1'b1; move_cell = 4'd2;
        @(negedge clk);
        move_valid = 1'b0; move_cell = 4'd0;
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk_cleared("t6_reset");
        resetn = 1'b1;
        model_clear();
        repeat (12) @(negedge clk);

        chk("scoreboard_drained", 18'(sb_q.size()), 18'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
